// File: rtl/md5_pkg.sv
//----------------------------------------------------------------------------
// Module : md5_pkg
// Brief  : Shared widths, sweep FSM encoding and ASCII hex helper for the
//          MD5 candidate sweep controller.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

package md5_pkg;

    localparam int TMPL_W   = 512;
    localparam int DIGEST_W = 128;

    localparam logic [7:0] ASCII_0 = 8'h30;   // '0'
    localparam logic [7:0] ASCII_A = 8'h61;   // 'a'

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_e;

    // One nibble to a lowercase ASCII hex character.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'd0, nib};
        end
        return ASCII_A + {4'd0, nib} - 8'd10;
    endfunction

endpackage

`default_nettype wire

// File: rtl/md5_hex_insert.sv
//----------------------------------------------------------------------------
// Module : md5_hex_insert
// Brief  : Combinational candidate builder. Overwrites eight template bytes,
//          starting at byte HEX_OFF (byte 0 = bits [511:504]), with the
//          lowercase ASCII hex rendering of value_i, most significant nibble
//          first.
// Ports  : tmpl_i  [511:0] padded template block
//          value_i [31:0]  counter value to render
//          cand_o  [511:0] resulting candidate block
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module md5_hex_insert
    import md5_pkg::*;
#(
    parameter int HEX_OFF = 0
) (
    input  logic [TMPL_W-1:0] tmpl_i,
    input  logic [31:0]       value_i,
    output logic [TMPL_W-1:0] cand_o
);

    always_comb begin
        cand_o = tmpl_i;
        for (int i = 0; i < 8; i++) begin
            cand_o[TMPL_W-1-8*(HEX_OFF+i) -: 8] = hex_ascii(value_i[31-4*i -: 4]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/md5_sweep_ctrl.sv
//----------------------------------------------------------------------------
// Module : md5_sweep_ctrl
// Brief  : Keeps a pipelined md5core fed with one candidate per clock,
//          counts retirements, records the first digest match and pulses
//          done once the pipeline has drained.
// Ports  : clk, reset (async, active-low)
//          start/abort/stop_on_match, template_in, target_in, start_idx,
//          count                       - host command side
//          busy, done, match_found, match_idx - host status side
//          core_en, core_m_in, core_valid_in  - to md5core
//          core_a..core_d, core_valid_out     - from md5core
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module md5_sweep_ctrl
    import md5_pkg::*;
#(
    parameter int HEX_OFF    = 0,
    parameter int INFLIGHT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              stop_on_match,
    input  logic [TMPL_W-1:0] template_in,
    input  logic [127:0]      target_in,
    input  logic [31:0]       start_idx,
    input  logic [31:0]       count,
    output logic              busy,
    output logic              done,
    output logic              match_found,
    output logic [31:0]       match_idx,
    output logic              core_en,
    output logic [TMPL_W-1:0] core_m_in,
    output logic              core_valid_in,
    input  logic [31:0]       core_a,
    input  logic [31:0]       core_b,
    input  logic [31:0]       core_c,
    input  logic [31:0]       core_d,
    input  logic              core_valid_out
);

    sweep_state_e            state_q, state_d;
    logic [TMPL_W-1:0]       template_q, template_d;
    logic [DIGEST_W-1:0]     target_q, target_d;
    logic [31:0]             start_idx_q, start_idx_d;
    logic [31:0]             count_q, count_d;
    logic                    stop_q, stop_d;
    logic [31:0]             issue_cnt_q, issue_cnt_d;
    logic [31:0]             retire_cnt_q, retire_cnt_d;
    logic [INFLIGHT_W-1:0]   inflight_q, inflight_d;
    logic                    match_found_q, match_found_d;
    logic [31:0]             match_idx_q, match_idx_d;
    logic                    valid_in_q, valid_in_d;
    logic [TMPL_W-1:0]       m_in_q, m_in_d;

    logic                    w_retire;
    logic                    w_new_match;
    logic [TMPL_W-1:0]       w_ins_tmpl;
    logic [31:0]             w_ins_val;
    logic [TMPL_W-1:0]       w_cand;

    // A valid_out with nothing in flight is stray and never retires.
    assign w_retire    = core_valid_out && (inflight_q != '0);
    assign w_new_match = w_retire && !match_found_q &&
                         ({core_a, core_b, core_c, core_d} == target_q);

    // issue_cnt_q is the index of the candidate currently on core_m_in.
    // The first candidate is built straight from the host inputs so that it
    // is presented the cycle after start; later ones use the latched copies.
    assign w_ins_tmpl = (state_q == ST_IDLE) ? template_in : template_q;
    assign w_ins_val  = (state_q == ST_IDLE) ? start_idx
                                             : start_idx_q + issue_cnt_q + 32'd1;

    md5_hex_insert #(
        .HEX_OFF (HEX_OFF)
    ) u_hex_insert (
        .tmpl_i  (w_ins_tmpl),
        .value_i (w_ins_val),
        .cand_o  (w_cand)
    );

    always_comb begin
        state_d       = state_q;
        template_d    = template_q;
        target_d      = target_q;
        start_idx_d   = start_idx_q;
        count_d       = count_q;
        stop_d        = stop_q;
        issue_cnt_d   = issue_cnt_q;
        retire_cnt_d  = retire_cnt_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        valid_in_d    = 1'b0;
        m_in_d        = '0;
        inflight_d    = inflight_q + INFLIGHT_W'(valid_in_q) - INFLIGHT_W'(w_retire);

        if (w_retire) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
        if (w_new_match) begin
            match_found_d = 1'b1;
            match_idx_d   = start_idx_q + retire_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    template_d    = template_in;
                    target_d      = target_in;
                    start_idx_d   = start_idx;
                    count_d       = count;
                    stop_d        = stop_on_match;
                    issue_cnt_d   = '0;
                    retire_cnt_d  = '0;
                    match_found_d = 1'b0;
                    match_idx_d   = '0;
                    if (count != '0) begin
                        state_d    = ST_RUN;
                        valid_in_d = 1'b1;
                        m_in_d     = w_cand;
                    end else begin
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if ((issue_cnt_q == count_q - 32'd1) || abort ||
                    (stop_q && w_new_match)) begin
                    state_d = ST_DRAIN;
                end else begin
                    valid_in_d  = 1'b1;
                    m_in_d      = w_cand;
                    issue_cnt_d = issue_cnt_q + 32'd1;
                end
            end
            ST_DRAIN: begin
                if ((inflight_q == '0) && !core_valid_out) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            template_q    <= '0;
            target_q      <= '0;
            start_idx_q   <= '0;
            count_q       <= '0;
            stop_q        <= 1'b0;
            issue_cnt_q   <= '0;
            retire_cnt_q  <= '0;
            inflight_q    <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            valid_in_q    <= 1'b0;
            m_in_q        <= '0;
        end else begin
            state_q       <= state_d;
            template_q    <= template_d;
            target_q      <= target_d;
            start_idx_q   <= start_idx_d;
            count_q       <= count_d;
            stop_q        <= stop_d;
            issue_cnt_q   <= issue_cnt_d;
            retire_cnt_q  <= retire_cnt_d;
            inflight_q    <= inflight_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            valid_in_q    <= valid_in_d;
            m_in_q        <= m_in_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign core_en       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign core_valid_in = valid_in_q;
    assign core_m_in     = m_in_q;
    assign match_found   = match_found_q;
    assign match_idx     = match_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_md5_sweep_ctrl.sv
//----------------------------------------------------------------------------
// Module : tb_md5_sweep_ctrl
// Brief  : Self-checking bench for md5_sweep_ctrl with a behavioural
//          pipelined MD5 core and a candidate scoreboard.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_md5_sweep_ctrl;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, abort = 1'b0, stop_on_match = 1'b0;
    logic [511:0] template_in = '0;
    logic [127:0] target_in = '0;
    logic [31:0]  start_idx = '0, count = '0;
    logic         busy, done, match_found, core_en, core_valid_in, core_valid_out;
    logic [31:0]  match_idx, core_a, core_b, core_c, core_d;
    logic [511:0] core_m_in;

    always #5 clk = ~clk;

    md5_sweep_ctrl #(.HEX_OFF(0), .INFLIGHT_W(8)) dut (
        .clk(clk), .reset(rst_n), .start(start), .abort(abort),
        .stop_on_match(stop_on_match), .template_in(template_in),
        .target_in(target_in), .start_idx(start_idx), .count(count),
        .busy(busy), .done(done), .match_found(match_found), .match_idx(match_idx),
        .core_en(core_en), .core_m_in(core_m_in), .core_valid_in(core_valid_in),
        .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
        .core_valid_out(core_valid_out)
    );

    // ---------------- reference MD5 of one block ----------------
    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [127:0] md5_blk(input logic [511:0] m);
        logic [31:0] w[16];
        logic [31:0] a, b, c, d, f, k, tmp;
        int sh[16];
        int g;
        real r;
        sh = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
        for (int i = 0; i < 16; i++)
            w[i] = {m[511-8*(4*i+3) -: 8], m[511-8*(4*i+2) -: 8],
                    m[511-8*(4*i+1) -: 8], m[511-8*(4*i) -: 8]};
        a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0: begin f = (b & c) | (~b & d); g = i;              end
                1: begin f = (d & b) | (~d & c); g = (5*i + 1) % 16; end
                2: begin f = b ^ c ^ d;          g = (3*i + 5) % 16; end
                default: begin f = c ^ (b | ~d); g = (7*i) % 16;     end
            endcase
            r = $sin(real'(i + 1));
            if (r < 0.0) r = -r;
            k = 32'(longint'($floor(r * 4294967296.0)));
            tmp = d; d = c; c = b;
            b = b + rotl(a + f + k + w[g], sh[(i/16)*4 + i%4]);
            a = tmp;
        end
        return {a + 32'h67452301, b + 32'hefcdab89, c + 32'h98badcfe, d + 32'h10325476};
    endfunction

    // Padded single block for a short ASCII message.
    function automatic logic [511:0] make_block(input string s);
        logic [511:0] blk;
        blk = '0;
        for (int i = 0; i < s.len(); i++) blk[511-8*i -: 8] = s[i];
        blk[511-8*s.len() -: 8] = 8'h80;
        blk[511-8*56 -: 8] = 8'(s.len() * 8);
        return blk;
    endfunction

    function automatic logic [511:0] cand(input logic [31:0] v);
        return make_block($sformatf("%08h", v));
    endfunction

    // ---------------- behavioural pipelined core ----------------
    logic [DEPTH-1:0] pv;
    logic [127:0]     pd [DEPTH];
    logic             stray = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            for (int i = 0; i < DEPTH; i++) pd[i] <= '0;
        end else if (core_en) begin
            pv    <= {pv[DEPTH-2:0], core_valid_in};
            pd[0] <= md5_blk(core_m_in);
            for (int i = 1; i < DEPTH; i++) pd[i] <= pd[i-1];
        end
    end

    assign core_valid_out = pv[DEPTH-1] | stray;
    assign {core_a, core_b, core_c, core_d} = pd[DEPTH-1];

    // ---------------- checking ----------------
    int n_cmp = 0, n_bad = 0;
    int n_issued = 0, n_retired = 0, n_after_match = 0;
    logic [511:0] exp_q[$];

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (core_valid_in) begin
                n_issued++;
                if (match_found) n_after_match++;
                chk("sb_nonempty", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) chk("cand", core_m_in, exp_q.pop_front());
            end
            if (pv[DEPTH-1]) n_retired++;
        end
    end

    int  cyc;
    bit  tmo;
    logic busy_at_done;

    // Runs one sweep; glitch_at re-pulses start while busy, abort_at pulses abort.
    task automatic sweep(input string name, input logic stop, input logic [31:0] sidx,
                         input logic [31:0] cnt, input logic [127:0] tgt,
                         input int abort_at, input int glitch_at);
        exp_q.delete();
        n_issued = 0; n_retired = 0; n_after_match = 0;
        for (int k = 0; k < int'(cnt) && k < 2000; k++) exp_q.push_back(cand(sidx + 32'(k)));
        @(posedge clk); #1;
        start = 1'b1; stop_on_match = stop; template_in = make_block("00000000");
        target_in = tgt; start_idx = sidx; count = cnt;
        @(posedge clk); #1;
        start = 1'b0; stop_on_match = 1'b0; template_in = '0;
        target_in = {4{$urandom}}; start_idx = $urandom; count = 32'd0;
        cyc = 0; tmo = 1'b1;
        while (cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (done) begin tmo = 1'b0; break; end
            abort = (cyc == abort_at);
            start = (cyc == glitch_at);
        end
        abort = 1'b0; start = 1'b0;
        busy_at_done = busy;
        chk({name, "_done_tmo"}, tmo, 1'b0);
        if (tmo) begin
            rst_n = 1'b0; #2; rst_n = 1'b1;
        end else begin
            @(negedge clk);
            chk({name, "_done_pulse"}, done, 1'b0);
            chk({name, "_idle_busy"}, busy, 1'b0);
        end
    endtask

    logic [127:0] tgt;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_outs", {busy, done, match_found, match_idx, core_en, core_valid_in}, '0);
        chk("rst_m_in", core_m_in, '0);
        rst_n = 1'b1;

        // Basic sweep with a match at index 2 (counter 0x2a)
        tgt = md5_blk(cand(32'h2a));
        sweep("t1", 1'b0, 32'h28, 32'd5, tgt, -1, -1);
        chk("t1_found", match_found, 1'b1);
        chk("t1_idx", match_idx, 32'h2a);
        chk("t1_issued", n_issued, 5);
        chk("t1_retired", n_retired, 5);
        chk("t1_sb_empty", exp_q.size(), 0);

        // Empty sweep
        sweep("t2", 1'b0, 32'h5, 32'd0, tgt, -1, -1);
        chk("t2_done_lat", cyc, 1);
        chk("t2_busy", busy_at_done, 1'b1);
        chk("t2_issued", n_issued, 0);
        chk("t2_found_clr", match_found, 1'b0);

        // Counter wrap, match on the wrapped value 1, start re-pulsed while busy
        tgt = md5_blk(cand(32'h1));
        sweep("t3", 1'b0, 32'hffff_fffe, 32'd4, tgt, -1, 2);
        chk("t3_found", match_found, 1'b1);
        chk("t3_idx", match_idx, 32'h1);
        chk("t3_issued", n_issued, 4);
        chk("t3_sb_empty", exp_q.size(), 0);

        // Stop on match at index 3 of 100
        tgt = md5_blk(cand(32'h103));
        sweep("t4", 1'b1, 32'h100, 32'd100, tgt, -1, -1);
        chk("t4_found", match_found, 1'b1);
        chk("t4_idx", match_idx, 32'h103);
        chk("t4_after_match", n_after_match <= 1, 1'b1);
        chk("t4_early_stop", n_issued < 20, 1'b1);
        chk("t4_drained", n_issued, n_retired);

        // Abort 10 cycles into a long sweep, non-matching target
        tgt = md5_blk(make_block("nomatch"));
        sweep("t5", 1'b0, 32'h0, 32'd1000, tgt, 10, -1);
        chk("t5_found", match_found, 1'b0);
        chk("t5_stop", (n_issued >= 10) && (n_issued <= 11), 1'b1);
        chk("t5_drained", n_issued, n_retired);
        chk("t5_pipe_empty", pv, '0);

        // Reset in the middle of RUN
        exp_q.delete();
        for (int k = 0; k < 50; k++) exp_q.push_back(cand(32'h300 + 32'(k)));
        @(posedge clk); #1;
        start = 1'b1; template_in = make_block("00000000"); target_in = tgt;
        start_idx = 32'h300; count = 32'd50;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("t6_running", core_valid_in, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outs", {busy, done, match_found, match_idx, core_en, core_valid_in}, '0);
        chk("t6_rst_m_in", core_m_in, '0);
        @(negedge clk); rst_n = 1'b1;

        // Stray valid_out while idle must not disturb the next sweep
        @(negedge clk); stray = 1'b1;
        @(negedge clk); stray = 1'b0;
        tgt = md5_blk(cand(32'h501));
        sweep("t6", 1'b0, 32'h500, 32'd3, tgt, -1, -1);
        chk("t6_found", match_found, 1'b1);
        chk("t6_idx", match_idx, 32'h501);
        chk("t6_issued", n_issued, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
